// File: rtl/xentry_pkg.sv
// Shared xentry types: L2 transfer kinds and the line-port FSM states.
package xentry_pkg;

  typedef enum logic {L2_FILL, L2_WRITEBACK} l2_xfer_e;

  typedef enum logic [1:0] {
    L2P_IDLE,
    L2P_REQ,
    L2P_WAIT_RESP,
    L2P_DONE
  } l2_port_state_e;

endpackage

// File: rtl/dcache_l2_watchdog.sv
// Per-word watchdog for the dcache L2 port: counts cycles of a single word transfer
// and flags expiry once TIMEOUT_CYCLES have elapsed since the last clear.
module dcache_l2_watchdog
  import xentry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // The clearing cycle itself counts as the first cycle of the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= CW'(1);
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dcache_l2_port.sv
// Line-transfer engine between the dcache and the L2 port, one word per request.
// Optional per-word watchdog enabled by defining XENTRY_L2_TIMEOUT_EN.
module dcache_l2_port
  import xentry_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int LINE_SIZE      = 32,
  parameter int OFS_SIZE       = 5,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int WORDS_PER_LINE   = LINE_SIZE / (XLEN / 8),
  localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE),
  localparam int BYTE_SELECT_SIZE = $clog2(XLEN / 8)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        xfer_start,
  input  l2_xfer_e                    xfer_type,
  input  logic [XLEN-OFS_SIZE-1:0]    xfer_block_address,
  output logic                        xfer_busy,
  output logic                        xfer_done,
  output logic                        xfer_error,
  output logic [WORD_SELECT_SIZE-1:0] cache_word_index,
  input  logic [XLEN-1:0]             cache_word_to_store,
  output logic [XLEN-1:0]             cache_fetched_word,
  output logic                        cache_fetched_valid,
  output logic                        l2_req_valid,
  input  logic                        l2_req_ready,
  output logic [XLEN-1:0]             l2_req_address,
  output logic                        l2_req_write,
  output logic [XLEN-1:0]             l2_req_wdata,
  input  logic                        l2_resp_valid,
  input  logic [XLEN-1:0]             l2_resp_rdata
);

  localparam logic [WORD_SELECT_SIZE-1:0] LAST_INDEX = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);

  l2_port_state_e              state, state_next;
  logic [WORD_SELECT_SIZE-1:0] index, index_next;
  l2_xfer_e                    type_q;
  logic [XLEN-OFS_SIZE-1:0]    block_q;
  logic                        start, accept, resp, expired;

  assign start  = (state == L2P_IDLE) && xfer_start;
  assign accept = l2_req_valid && l2_req_ready;
  assign resp   = (state == L2P_WAIT_RESP) && l2_resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= L2P_IDLE;
      index   <= LAST_INDEX;
      type_q  <= L2_FILL;
      block_q <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
      if (start) begin
        type_q  <= xfer_type;
        block_q <= xfer_block_address;
      end
    end
  end

  // Words move from the top index down; index 0 is terminal and never wraps.
  always_comb begin
    state_next = state;
    index_next = index;
    case (state)
      L2P_IDLE: begin
        if (xfer_start) begin
          state_next = L2P_REQ;
          index_next = LAST_INDEX;
        end
      end
      L2P_REQ: begin
        if (expired) begin
          state_next = L2P_DONE;
        end else if (l2_req_ready) begin
          state_next = L2P_WAIT_RESP;
        end
      end
      L2P_WAIT_RESP: begin
        if (l2_resp_valid) begin
          if (index == '0) begin
            state_next = L2P_DONE;
          end else begin
            index_next = index - 1'b1;
            state_next = L2P_REQ;
          end
        end else if (expired) begin
          state_next = L2P_DONE;
        end
      end
      L2P_DONE: state_next = L2P_IDLE;
      default:  state_next = L2P_IDLE;
    endcase
  end

`ifdef XENTRY_L2_TIMEOUT_EN
  logic error_q;

  dcache_l2_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (start || accept || resp),
    .enable ((state == L2P_REQ) || (state == L2P_WAIT_RESP)),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (start) begin
      error_q <= 1'b0;
    end else if (expired) begin
      error_q <= 1'b1;
    end
  end

  assign xfer_error = error_q;
`else
  assign expired    = 1'b0;
  assign xfer_error = 1'b0;
`endif

  assign xfer_busy           = (state != L2P_IDLE);
  assign xfer_done           = (state == L2P_DONE);
  assign cache_word_index    = index;
  assign l2_req_valid        = (state == L2P_REQ) && !expired;
  assign l2_req_address      = {block_q, index, {BYTE_SELECT_SIZE{1'b0}}};
  assign l2_req_write        = (type_q == L2_WRITEBACK);
  assign l2_req_wdata        = cache_word_to_store;
  assign cache_fetched_valid = resp && (type_q == L2_FILL);
  assign cache_fetched_word  = cache_fetched_valid ? l2_resp_rdata : '0;

endmodule

// File: tb/tb_dcache_l2_port.sv
// Directed bench for dcache_l2_port: fill, stalled writeback, ignored start,
// spurious responses, reset mid-fill, and the watchdog when XENTRY_L2_TIMEOUT_EN is set.
module tb_dcache_l2_port;
  import xentry_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        xfer_start;
  l2_xfer_e    xfer_type;
  logic [26:0] xfer_block_address;
  logic        xfer_busy, xfer_done, xfer_error;
  logic [2:0]  cache_word_index;
  logic [31:0] cache_word_to_store;
  logic [31:0] cache_fetched_word;
  logic        cache_fetched_valid;
  logic        l2_req_valid, l2_req_ready;
  logic [31:0] l2_req_address;
  logic        l2_req_write;
  logic [31:0] l2_req_wdata;
  logic        l2_resp_valid;
  logic [31:0] l2_resp_rdata;

  int tests = 0;
  int fails = 0;

  dcache_l2_port #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .xfer_start         (xfer_start),
    .xfer_type          (xfer_type),
    .xfer_block_address (xfer_block_address),
    .xfer_busy          (xfer_busy),
    .xfer_done          (xfer_done),
    .xfer_error         (xfer_error),
    .cache_word_index   (cache_word_index),
    .cache_word_to_store(cache_word_to_store),
    .cache_fetched_word (cache_fetched_word),
    .cache_fetched_valid(cache_fetched_valid),
    .l2_req_valid       (l2_req_valid),
    .l2_req_ready       (l2_req_ready),
    .l2_req_address     (l2_req_address),
    .l2_req_write       (l2_req_write),
    .l2_req_wdata       (l2_req_wdata),
    .l2_resp_valid      (l2_resp_valid),
    .l2_resp_rdata      (l2_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Land 1 time unit after the rising edge, where new inputs are driven.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input l2_xfer_e kind, input logic [26:0] block,
                               input logic ready, input logic rvalid, input logic [31:0] rdata,
                               input logic [31:0] store);
    xfer_start          = start;
    xfer_type           = kind;
    xfer_block_address  = block;
    l2_req_ready        = ready;
    l2_resp_valid       = rvalid;
    l2_resp_rdata       = rdata;
    cache_word_to_store = store;
  endtask

  // Fill with ready always high and l2_resp_valid held high throughout, so odd (REQ)
  // cycles also carry a spurious response. Optionally re-pulses xfer_start in cycle 5.
  task automatic runFill(input logic [26:0] block, input logic with_restart);
    int          w;
    logic [31:0] exp_addr;
    applyStimulus(1'b1, L2_FILL, block, 1'b1, 1'b1, 32'h0, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      nextCycle();
      if (with_restart && c == 5)
        applyStimulus(1'b1, L2_WRITEBACK, 27'h0000456, 1'b1, 1'b1, 32'hA500_0000 + c, 32'h0);
      else
        applyStimulus(1'b0, L2_FILL, block, 1'b1, c <= 16, 32'hA500_0000 + c, 32'h0);
      #1;
      if (c <= 16) begin
        w        = 7 - (c - 1) / 2;
        exp_addr = {block, 3'(w), 2'b00};
        checkOutput("fill_index", 32'(cache_word_index), 32'(w));
        if (c % 2 == 1) begin
          checkOutput("fill_req_valid", 32'(l2_req_valid), 32'd1);
          checkOutput("fill_req_addr", l2_req_address, exp_addr);
          checkOutput("fill_req_write", 32'(l2_req_write), 32'd0);
          checkOutput("fill_spurious_resp", 32'(cache_fetched_valid), 32'd0);
        end else begin
          checkOutput("fill_req_valid_wait", 32'(l2_req_valid), 32'd0);
          checkOutput("fill_fetched_valid", 32'(cache_fetched_valid), 32'd1);
          checkOutput("fill_fetched_word", cache_fetched_word, 32'hA500_0000 + c);
        end
      end
      checkOutput("fill_busy", 32'(xfer_busy), 32'(c <= 17));
      checkOutput("fill_done", 32'(xfer_done), 32'(c == 17));
    end
  endtask

  // Writeback with l2_req_ready low for 3 cycles per word, ack one cycle after acceptance.
  task automatic runWriteback(input logic [26:0] block);
    int w, ph;
    applyStimulus(1'b1, L2_WRITEBACK, block, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 42; c++) begin
      nextCycle();
      w  = 7 - (c - 1) / 5;
      ph = (c - 1) % 5;
      if (c <= 40)
        applyStimulus(1'b0, L2_WRITEBACK, block, ph == 3, ph == 4, 32'hFFFF_FFFF, 32'hD000_0000 + w);
      else
        applyStimulus(1'b0, L2_WRITEBACK, block, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      if (c <= 40) begin
        checkOutput("wb_index", 32'(cache_word_index), 32'(w));
        if (ph < 4) begin
          checkOutput("wb_req_valid", 32'(l2_req_valid), 32'd1);
          checkOutput("wb_req_addr", l2_req_address, {block, 3'(w), 2'b00});
          checkOutput("wb_req_write", 32'(l2_req_write), 32'd1);
          checkOutput("wb_req_wdata", l2_req_wdata, 32'hD000_0000 + w);
        end else begin
          checkOutput("wb_req_valid_wait", 32'(l2_req_valid), 32'd0);
          checkOutput("wb_no_fetch", 32'(cache_fetched_valid), 32'd0);
        end
      end
      checkOutput("wb_busy", 32'(xfer_busy), 32'(c <= 41));
      checkOutput("wb_done", 32'(xfer_done), 32'(c == 41));
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, L2_FILL, 27'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(xfer_busy), 32'd0);
    checkOutput("rst_done", 32'(xfer_done), 32'd0);
    checkOutput("rst_error", 32'(xfer_error), 32'd0);
    checkOutput("rst_index", 32'(cache_word_index), 32'd7);
    checkOutput("rst_req_valid", 32'(l2_req_valid), 32'd0);
    checkOutput("rst_req_addr", l2_req_address, 32'h0000_001C);
    checkOutput("rst_fetched_valid", 32'(cache_fetched_valid), 32'd0);

    $display("[TB] fill block 0x123 with ignored restart");
    runFill(27'h0000123, 1'b1);

    $display("[TB] stalled writeback block 0x1F0");
    runWriteback(27'h00001F0);

    $display("[TB] reset during word 4 of a fill");
    applyStimulus(1'b1, L2_FILL, 27'h0000321, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      applyStimulus(1'b0, L2_FILL, 27'h0000321, 1'b1, c % 2 == 0, 32'h0, 32'h0);
    end
    #1;
    checkOutput("pre_rst_index", 32'(cache_word_index), 32'd4);
    checkOutput("pre_rst_req_valid", 32'(l2_req_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_req_valid", 32'(l2_req_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(xfer_busy), 32'd0);
    checkOutput("async_rst_index", 32'(cache_word_index), 32'd7);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput("rst_no_done", 32'(xfer_done), 32'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_rst_index", 32'(cache_word_index), 32'd7);
    runFill(27'h0000321, 1'b0);

`ifdef XENTRY_L2_TIMEOUT_EN
    $display("[TB] watchdog on missing word-7 response");
    applyStimulus(1'b1, L2_FILL, 27'h0000077, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      nextCycle();
      applyStimulus(c == 18, L2_FILL, 27'h0000077, c == 1, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("wd_done", 32'(xfer_done), 32'(c == 17));
      checkOutput("wd_error", 32'(xfer_error), 32'(c >= 17));
      checkOutput("wd_busy", 32'(xfer_busy), 32'(c <= 17));
    end
    nextCycle();
    applyStimulus(1'b0, L2_FILL, 27'h0000077, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("wd_error_cleared", 32'(xfer_error), 32'd0);
    checkOutput("wd_restart_busy", 32'(xfer_busy), 32'd1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
